attack_sequencer: RTL and testbench
===================================

ATTACK_SEQUENCER -- requirements
Module: attack_sequencer

Interface
REQ-001 Parameter MAX_SHOTS, default 12, shots available per game (1..15).
REQ-002 Parameter SHIP_W, default 4, width of shot/hit counters.
REQ-003 clk  in  1  divided game clock; one clock domain, all state on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 start  in  1  game-enable level from the mode switch; 0 forces the game back to idle.
REQ-006 lock_map  in  1  single-cycle pulse: the player has fixed the map and attack begins.
REQ-007 confirm  in  1  debounced attack button, active-high level.
REQ-008 x_coord  in  3  target column; valid range 0..6.
REQ-009 y_coord  in  3  target row; valid range 0..4.
REQ-010 cell_is_ship  in  1  map bit at (x_coord, y_coord).
REQ-011 cell_already_hit  in  1  hits-register bit at (x_coord, y_coord).
REQ-012 ship_cells  in  SHIP_W  number of ship cells in the selected map.
REQ-013 state  out  2  00 IDLE, 01 PREP, 10 ATTACK, 11 OVER; drives the existing game_state_code path.
REQ-014 hit_strobe  out  1  one-cycle pulse that sets the hits-register bit at the current coordinate.
REQ-015 shots_left  out  SHIP_W  remaining shots.
REQ-016 hits  out  SHIP_W  ship cells hit so far.
REQ-017 led_green, led_red  out  1 each  result of the last accepted shot (miss / hit).
REQ-018 win  out  1  high in OVER when all ship cells were hit.

Function
REQ-019 FSM transitions: IDLE->PREP when start=1; PREP->ATTACK on lock_map=1; ATTACK->OVER on the end condition (REQ-025).
REQ-020 start=0 in any state SHALL move to IDLE on the next edge, clearing counters, LEDs and win; this overrides every other transition.
REQ-021 On PREP->ATTACK: register ship_cells; set shots_left=MAX_SHOTS and hits=0.
REQ-022 confirm edge: rising edge of confirm, detected against a one-cycle-delayed copy; a held button SHALL count as one edge only.
REQ-023 Shot acceptance: in ATTACK, a confirm edge with x_coord<=6, y_coord<=4, cell_already_hit=0 and shots_left>0 SHALL be accepted. Accepted-shot actions, on the next edge:
- hit_strobe=1 for exactly one cycle;
- shots_left decrements by 1;
- hits increments by 1 if cell_is_ship=1;
- led_red=cell_is_ship and led_green=~cell_is_ship.
REQ-024 Rejected edges (invalid coordinate or already hit) SHALL produce no strobe, no counter change, and no LED change.
REQ-025 End condition, evaluated on registered counters the cycle after an update:
- hits==registered ship_cells -> OVER with win=1;
- otherwise shots_left==0 -> OVER with win=0;
- if both hold on the same final shot, win SHALL take priority.
REQ-026 A registered ship_cells of 0 SHALL take ATTACK->OVER with win=1 on the first ATTACK cycle.
REQ-027 OVER holds; counters, LEDs and win are frozen, and confirm edges are ignored until start=0.
REQ-028 Outside ATTACK and OVER, led_green, led_red and hit_strobe are 0.
REQ-029 Counters never wrap: shots_left saturates at 0 and hits at 2^SHIP_W-1.

Reset
REQ-030 Asynchronous reset SHALL force the following, and hold them while reset=1:
- state=IDLE;
- shots_left=0, hits=0;
- hit_strobe=0, LEDs=0, win=0;
- registered ship_cells=0;
- confirm delay register=1, so a button held through reset yields no edge.

Structure
REQ-031 Shared package SHALL hold the state encoding constants (IDLE/PREP/ATTACK/OVER), the coordinate limits (X_MAX=6, Y_MAX=4) and the MAX_SHOTS default.
REQ-032 One sub-module is natural: edge_detector (rising-edge pulse with async reset), reusable by other button paths.
REQ-033 FSM, counters and LED registers live in attack_sequencer; outputs are registered, with no combinational input-to-output paths.

Verification
REQ-034 reset, start=1 -> PREP; lock_map pulse with ship_cells=3 -> ATTACK, shots_left=12, hits=0.
REQ-035 In ATTACK, confirm rise at (2,1) with cell_is_ship=1 -> one-cycle hit_strobe, hits=1, shots_left=11, led_red=1; holding confirm high 20 cycles -> no further strobe.
REQ-036 confirm at x=7, then at a cell with cell_already_hit=1 -> no strobe; counters and LEDs unchanged.
REQ-037 MAX_SHOTS=2, two misses -> shots_left=0, then OVER with win=0; a third confirm is ignored.
REQ-038 ship_cells=1, last shot hits with shots_left 1->0 -> OVER, win=1 (priority); start=0 -> IDLE with all outputs 0.
REQ-039 reset asserted mid-ATTACK with hits=2 -> state=00 and counters 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/attack_sequencer_pkg.sv
// Shared definitions for the attack sequencer: game-state encoding,
// playfield coordinate limits and the default shot budget.
package attack_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PREP   = 2'b01,
        ATTACK = 2'b10,
        OVER   = 2'b11
    } state_t;

    localparam logic [2:0] X_MAX = 3'd6;
    localparam logic [2:0] Y_MAX = 3'd4;

    localparam int MAX_SHOTS_DEFAULT = 12;

    // True when the target lies on the 7x5 playfield.
    function automatic logic coord_valid(input logic [2:0] x, input logic [2:0] y);
        return (x <= X_MAX) && (y <= Y_MAX);
    endfunction

endpackage

// File: rtl/attack_sequencer_edge_detector.sv
// Rising-edge detector for a debounced button level. The history flop
// resets to RESET_LEVEL so a button held through reset does not fire.
module edge_detector #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Next history value is simply the current level.
    always_comb begin
        prev_d = level;
    end

    // One-cycle-delayed copy of the level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= RESET_LEVEL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/attack_sequencer.sv
// Attack-phase sequencer for the battleship game: walks IDLE/PREP/ATTACK/OVER,
// accepts shots on confirm edges, keeps shot and hit counters and result LEDs.
// All outputs come straight from flops.
module attack_sequencer
    import attack_sequencer_pkg::*;
#(
    parameter int MAX_SHOTS = MAX_SHOTS_DEFAULT,
    parameter int SHIP_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              lock_map,
    input  logic              confirm,
    input  logic [2:0]        x_coord,
    input  logic [2:0]        y_coord,
    input  logic              cell_is_ship,
    input  logic              cell_already_hit,
    input  logic [SHIP_W-1:0] ship_cells,
    output logic [1:0]        state,
    output logic              hit_strobe,
    output logic [SHIP_W-1:0] shots_left,
    output logic [SHIP_W-1:0] hits,
    output logic              led_green,
    output logic              led_red,
    output logic              win
);

    localparam logic [SHIP_W-1:0] SHOTS_INIT = SHIP_W'(MAX_SHOTS);
    localparam logic [SHIP_W-1:0] HITS_SAT   = '1;
    localparam logic [SHIP_W-1:0] ZERO       = '0;

    state_t            state_q, state_d;
    logic [SHIP_W-1:0] ship_q, ship_d;
    logic [SHIP_W-1:0] shots_q, shots_d;
    logic [SHIP_W-1:0] hits_q, hits_d;
    logic              strobe_q, strobe_d;
    logic              green_q, green_d;
    logic              red_q, red_d;
    logic              win_q, win_d;

    logic              confirm_rise;
    logic              shot_ok;

    edge_detector #(
        .RESET_LEVEL (1'b1)
    ) u_confirm_edge (
        .clk   (clk),
        .reset (reset),
        .level (confirm),
        .rise  (confirm_rise)
    );

    // A shot counts only on a fresh press at an untouched, on-board cell with budget left.
    always_comb begin
        shot_ok = confirm_rise
                  && coord_valid(x_coord, y_coord)
                  && !cell_already_hit
                  && (shots_q != ZERO);
    end

    // Next-state and counter logic; dropping start wins over everything else.
    always_comb begin
        state_d  = state_q;
        ship_d   = ship_q;
        shots_d  = shots_q;
        hits_d   = hits_q;
        strobe_d = 1'b0;
        green_d  = green_q;
        red_d    = red_q;
        win_d    = win_q;

        if (!start) begin
            state_d = IDLE;
            ship_d  = ZERO;
            shots_d = ZERO;
            hits_d  = ZERO;
            green_d = 1'b0;
            red_d   = 1'b0;
            win_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PREP;
                end
                PREP: begin
                    if (lock_map) begin
                        state_d = ATTACK;
                        ship_d  = ship_cells;
                        shots_d = SHOTS_INIT;
                        hits_d  = ZERO;
                    end
                end
                ATTACK: begin
                    if (hits_q == ship_q) begin
                        state_d = OVER;
                        win_d   = 1'b1;
                    end else if (shots_q == ZERO) begin
                        state_d = OVER;
                    end else if (shot_ok) begin
                        strobe_d = 1'b1;
                        shots_d  = shots_q - 1'b1;
                        if (cell_is_ship && (hits_q != HITS_SAT)) begin
                            hits_d = hits_q + 1'b1;
                        end
                        red_d   = cell_is_ship;
                        green_d = ~cell_is_ship;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Game state, counters and LED/result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ship_q   <= ZERO;
            shots_q  <= ZERO;
            hits_q   <= ZERO;
            strobe_q <= 1'b0;
            green_q  <= 1'b0;
            red_q    <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ship_q   <= ship_d;
            shots_q  <= shots_d;
            hits_q   <= hits_d;
            strobe_q <= strobe_d;
            green_q  <= green_d;
            red_q    <= red_d;
            win_q    <= win_d;
        end
    end

    assign state      = state_q;
    assign hit_strobe = strobe_q;
    assign shots_left = shots_q;
    assign hits       = hits_q;
    assign led_green  = green_q;
    assign led_red    = red_q;
    assign win        = win_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// Table-driven bench for attack_sequencer. Two instances share every input:
// dut1 uses the default 12-shot budget, dut2 a 2-shot budget. Each vector says
// which instance it checks.
module tb_attack_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       lock_map;
    logic       confirm;
    logic [2:0] x_coord;
    logic [2:0] y_coord;
    logic       cell_is_ship;
    logic       cell_already_hit;
    logic [3:0] ship_cells;

    logic [1:0] d1_state, d2_state;
    logic       d1_strobe, d2_strobe;
    logic [3:0] d1_shots, d2_shots;
    logic [3:0] d1_hits, d2_hits;
    logic       d1_green, d2_green;
    logic       d1_red, d2_red;
    logic       d1_win, d2_win;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic       lock;
        logic       conf;
        logic [2:0] x;
        logic [2:0] y;
        logic       ship;
        logic       hit;
        logic [3:0] cells;
        int         reps;
        bit         sel2;
        logic [1:0] e_state;
        logic       e_strobe;
        logic [3:0] e_shots;
        logic [3:0] e_hits;
        logic       e_green;
        logic       e_red;
        logic       e_win;
    } vec_t;

    vec_t tbl[$];
    vec_t seq[$];

    attack_sequencer dut1 (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .lock_map         (lock_map),
        .confirm          (confirm),
        .x_coord          (x_coord),
        .y_coord          (y_coord),
        .cell_is_ship     (cell_is_ship),
        .cell_already_hit (cell_already_hit),
        .ship_cells       (ship_cells),
        .state            (d1_state),
        .hit_strobe       (d1_strobe),
        .shots_left       (d1_shots),
        .hits             (d1_hits),
        .led_green        (d1_green),
        .led_red          (d1_red),
        .win              (d1_win)
    );

    attack_sequencer #(
        .MAX_SHOTS (2),
        .SHIP_W    (4)
    ) dut2 (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .lock_map         (lock_map),
        .confirm          (confirm),
        .x_coord          (x_coord),
        .y_coord          (y_coord),
        .cell_is_ship     (cell_is_ship),
        .cell_already_hit (cell_already_hit),
        .ship_cells       (ship_cells),
        .state            (d2_state),
        .hit_strobe       (d2_strobe),
        .shots_left       (d2_shots),
        .hits             (d2_hits),
        .led_green        (d2_green),
        .led_red          (d2_red),
        .win              (d2_win)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input int rst, input int st, input int lk, input int cf,
                                input int x, input int y, input int sh, input int ah,
                                input int cells, input int reps, input int sel2,
                                input int es, input int ek, input int esh, input int eh,
                                input int eg, input int er, input int ew);
        vec_t v;
        v.rst      = rst[0];
        v.start    = st[0];
        v.lock     = lk[0];
        v.conf     = cf[0];
        v.x        = 3'(x);
        v.y        = 3'(y);
        v.ship     = sh[0];
        v.hit      = ah[0];
        v.cells    = 4'(cells);
        v.reps     = reps;
        v.sel2     = sel2[0];
        v.e_state  = 2'(es);
        v.e_strobe = ek[0];
        v.e_shots  = 4'(esh);
        v.e_hits   = 4'(eh);
        v.e_green  = eg[0];
        v.e_red    = er[0];
        v.e_win    = ew[0];
        return v;
    endfunction

    task automatic checkField(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset            = v.rst;
        start            = v.start;
        lock_map         = v.lock;
        confirm          = v.conf;
        x_coord          = v.x;
        y_coord          = v.y;
        cell_is_ship     = v.ship;
        cell_already_hit = v.hit;
        ship_cells       = v.cells;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        if (v.sel2) begin
            checkField("d2_state",  idx, 8'(d2_state),  8'(v.e_state));
            checkField("d2_strobe", idx, 8'(d2_strobe), 8'(v.e_strobe));
            checkField("d2_shots",  idx, 8'(d2_shots),  8'(v.e_shots));
            checkField("d2_hits",   idx, 8'(d2_hits),   8'(v.e_hits));
            checkField("d2_green",  idx, 8'(d2_green),  8'(v.e_green));
            checkField("d2_red",    idx, 8'(d2_red),    8'(v.e_red));
            checkField("d2_win",    idx, 8'(d2_win),    8'(v.e_win));
        end else begin
            checkField("d1_state",  idx, 8'(d1_state),  8'(v.e_state));
            checkField("d1_strobe", idx, 8'(d1_strobe), 8'(v.e_strobe));
            checkField("d1_shots",  idx, 8'(d1_shots),  8'(v.e_shots));
            checkField("d1_hits",   idx, 8'(d1_hits),   8'(v.e_hits));
            checkField("d1_green",  idx, 8'(d1_green),  8'(v.e_green));
            checkField("d1_red",    idx, 8'(d1_red),    8'(v.e_red));
            checkField("d1_win",    idx, 8'(d1_win),    8'(v.e_win));
        end
    endtask

    task automatic runVec(input vec_t v, input int idx);
        for (int r = 0; r < v.reps; r++) begin
            applyStimulus(v);
            @(posedge clk);
            #1;
            checkOutput(v, idx);
        end
    endtask

    // Main test: table of directed vectors, then the asynchronous-reset sequence.
    initial begin
        reset = 1'b1; start = 1'b0; lock_map = 1'b0; confirm = 1'b0;
        x_coord = 3'd0; y_coord = 3'd0; cell_is_ship = 1'b0;
        cell_already_hit = 1'b0; ship_cells = 4'd0;

        //            rst st lk cf  x y sh ah cl  rp s2  st k  sh h g r w
        tbl.push_back(mk(1, 0, 0, 0, 0,0,0, 0, 0,  2, 0,  0,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 3,  1, 0,  1,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 1, 0, 0,0,0, 0, 3,  1, 0,  2,0,12,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 3,  1, 0,  2,0,12,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 1, 2,1,1, 0, 3,  1, 0,  2,1,11,1,0,1,0));
        tbl.push_back(mk(0, 1, 0, 1, 2,1,1, 0, 3, 20, 0,  2,0,11,1,0,1,0));
        tbl.push_back(mk(0, 1, 0, 0, 2,1,1, 0, 3,  1, 0,  2,0,11,1,0,1,0));
        tbl.push_back(mk(0, 1, 0, 1, 7,0,0, 0, 3,  1, 0,  2,0,11,1,0,1,0));
        tbl.push_back(mk(0, 1, 0, 0, 7,0,0, 0, 3,  1, 0,  2,0,11,1,0,1,0));
        tbl.push_back(mk(0, 1, 0, 1, 3,2,0, 1, 3,  1, 0,  2,0,11,1,0,1,0));
        tbl.push_back(mk(0, 1, 0, 0, 3,2,0, 1, 3,  1, 0,  2,0,11,1,0,1,0));
        tbl.push_back(mk(0, 1, 0, 1, 0,4,0, 0, 3,  1, 0,  2,1,10,1,1,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,4,0, 0, 3,  1, 0,  2,0,10,1,1,0,0));
        tbl.push_back(mk(0, 1, 0, 1, 6,5,1, 0, 3,  1, 0,  2,0,10,1,1,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 6,5,1, 0, 3,  1, 0,  2,0,10,1,1,0,0));
        tbl.push_back(mk(0, 1, 0, 1, 6,4,1, 0, 3,  1, 0,  2,1, 9,2,0,1,0));
        tbl.push_back(mk(0, 1, 0, 0, 6,4,1, 0, 2,  1, 0,  2,0, 9,2,0,1,0));
        tbl.push_back(mk(0, 1, 0, 1, 1,1,1, 0, 3,  1, 0,  2,1, 8,3,0,1,0));
        tbl.push_back(mk(0, 1, 0, 0, 1,1,1, 0, 3,  1, 0,  3,0, 8,3,0,1,1));
        tbl.push_back(mk(0, 1, 0, 1, 2,2,0, 0, 3,  1, 0,  3,0, 8,3,0,1,1));
        tbl.push_back(mk(0, 1, 0, 0, 2,2,0, 0, 3,  3, 0,  3,0, 8,3,0,1,1));
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0, 0, 3,  1, 0,  0,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 0,  1, 0,  1,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 1, 0, 0,0,0, 0, 0,  1, 0,  2,0,12,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 0,  1, 0,  3,0,12,0,0,0,1));
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0, 0, 0,  1, 0,  0,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 3,  1, 0,  1,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 1, 0,0,1, 0, 3,  1, 0,  1,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0, 0, 3,  1, 0,  0,0, 0,0,0,0,0));
        tbl.push_back(mk(1, 0, 0, 0, 0,0,0, 0, 0,  1, 1,  0,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 3,  1, 1,  1,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 1, 0, 0,0,0, 0, 3,  1, 1,  2,0, 2,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 3,  1, 1,  2,0, 2,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 1, 0,0,0, 0, 3,  1, 1,  2,1, 1,0,1,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 3,  1, 1,  2,0, 1,0,1,0,0));
        tbl.push_back(mk(0, 1, 0, 1, 1,0,0, 0, 3,  1, 1,  2,1, 0,0,1,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 1,0,0, 0, 3,  1, 1,  3,0, 0,0,1,0,0));
        tbl.push_back(mk(0, 1, 0, 1, 2,0,1, 0, 3,  1, 1,  3,0, 0,0,1,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 2,0,1, 0, 3,  3, 1,  3,0, 0,0,1,0,0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0, 0, 3,  1, 1,  0,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 1,  1, 1,  1,0, 0,0,0,0,0));
        tbl.push_back(mk(0, 1, 1, 0, 0,0,0, 0, 1,  1, 1,  2,0, 2,0,0,0,0));
        tbl.push_back(mk(0, 1, 0, 1, 3,3,0, 0, 1,  1, 1,  2,1, 1,0,1,0,0));
        tbl.push_back(mk(0, 1, 0, 0, 3,3,0, 0, 1,  1, 1,  2,0, 1,0,1,0,0));
        tbl.push_back(mk(0, 1, 0, 1, 4,2,1, 0, 1,  1, 1,  2,1, 0,1,0,1,0));
        tbl.push_back(mk(0, 1, 0, 0, 4,2,1, 0, 1,  1, 1,  3,0, 0,1,0,1,1));
        tbl.push_back(mk(0, 0, 0, 0, 0,0,0, 0, 1,  1, 1,  0,0, 0,0,0,0,0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            runVec(tbl[i], i);
        end

        //            rst st lk cf  x y sh ah cl  rp s2  st k  sh h g r w
        seq.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 3,  1, 0,  1,0, 0,0,0,0,0));
        seq.push_back(mk(0, 1, 1, 0, 0,0,0, 0, 3,  1, 0,  2,0,12,0,0,0,0));
        seq.push_back(mk(0, 1, 0, 1, 2,1,1, 0, 3,  1, 0,  2,1,11,1,0,1,0));
        seq.push_back(mk(0, 1, 0, 0, 2,1,1, 0, 3,  1, 0,  2,0,11,1,0,1,0));
        seq.push_back(mk(0, 1, 0, 1, 3,1,1, 0, 3,  1, 0,  2,1,10,2,0,1,0));
        for (int i = 0; i < seq.size(); i++) begin
            runVec(seq[i], 100 + i);
        end

        reset = 1'b1;
        #2;
        checkField("async_state",  200, 8'(d1_state),  8'd0);
        checkField("async_shots",  200, 8'(d1_shots),  8'd0);
        checkField("async_hits",   200, 8'(d1_hits),   8'd0);
        checkField("async_strobe", 200, 8'(d1_strobe), 8'd0);
        checkField("async_red",    200, 8'(d1_red),    8'd0);
        @(negedge clk);

        seq.delete();
        seq.push_back(mk(1, 1, 0, 1, 0,0,0, 0, 3,  2, 0,  0,0, 0,0,0,0,0));
        seq.push_back(mk(0, 1, 0, 1, 0,0,0, 0, 3,  1, 0,  1,0, 0,0,0,0,0));
        seq.push_back(mk(0, 1, 1, 1, 0,0,0, 0, 3,  1, 0,  2,0,12,0,0,0,0));
        seq.push_back(mk(0, 1, 0, 1, 0,0,0, 0, 3,  3, 0,  2,0,12,0,0,0,0));
        seq.push_back(mk(0, 1, 0, 0, 0,0,0, 0, 3,  1, 0,  2,0,12,0,0,0,0));
        seq.push_back(mk(0, 1, 0, 1, 5,3,0, 0, 3,  1, 0,  2,1,11,0,1,0,0));
        for (int i = 0; i < seq.size(); i++) begin
            runVec(seq[i], 300 + i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
